// File: rtl/fp_sqrt_pkg.sv
// Shared definitions for the sequential Newton-Raphson square-root block:
// FSM state encoding, IEEE-754 single constants and the iteration counter width.
`timescale 1ns/1ps
package fp_sqrt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    DIV  = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int          BIAS  = 127;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] PINF  = 32'h7F80_0000;
  localparam int          CNT_W = 4;

endpackage

// File: rtl/fp_sqrt_guess.sv
// Combinational initial guess for sqrt(A): the exponent is halved
// (signed, rounding toward minus infinity), and the mantissa is dropped.
`timescale 1ns/1ps
module fp_sqrt_guess
  import fp_sqrt_pkg::*;
(
  input  logic [31:0] operand,
  output logic [31:0] guess
);

  logic signed [9:0] unbiased;
  logic signed [9:0] halved;
  logic signed [9:0] rebiased;

  // Unbias, arithmetic-shift by one, rebias; only the low 8 bits form the exponent field.
  always_comb begin
    unbiased = $signed({2'b00, operand[30:23]}) - 10'(BIAS);
    halved   = unbiased >>> 1;
    rebiased = halved + 10'(BIAS);
    guess    = {1'b0, rebiased[7:0], 23'b0};
  end

endmodule

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754 single-precision square root by Newton-Raphson:
// X <- (X + A/X) / 2, ITERS times, using an external shared divider and adder.
// Optional macro FP_SQRT_SPECIAL_EN adds zero/negative/Inf/NaN short-cuts in INIT.
`timescale 1ns/1ps
module fp_sqrt_seq
  import fp_sqrt_pkg::*;
#(
  parameter int ITERS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] data_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic [31:0] div_res_i,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  input  logic [31:0] add_res_i
);

  localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        a_reg;
  logic [31:0]        x_reg;
  logic [31:0]        q_reg;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [31:0]        guess;
  logic               accept;
  logic               special_hit;
  logic [31:0]        special_val;

  // Halving a float by decrementing its exponent; a zero exponent collapses to 0.
  function automatic logic [31:0] halve(input logic [31:0] s);
    if (s[30:23] == 8'd0) return 32'd0;
    return {s[31], s[30:23] - 8'd1, s[22:0]};
  endfunction

  fp_sqrt_guess u_guess (
    .operand(a_reg),
    .guess  (guess)
  );

`ifdef FP_SQRT_SPECIAL_EN
  // Classify the captured operand for results that need no iteration.
  always_comb begin
    special_hit = 1'b1;
    special_val = 32'd0;
    if (a_reg[30:23] == 8'd0)                               special_val = 32'd0;
    else if (a_reg[30:23] == 8'hFF && a_reg[22:0] != 23'd0) special_val = QNAN;
    else if (a_reg[31])                                     special_val = QNAN;
    else if (a_reg[30:23] == 8'hFF)                         special_val = PINF;
    else                                                    special_hit = 1'b0;
  end
`else
  assign special_hit = 1'b0;
  assign special_val = 32'd0;
`endif

  // A start landing on the done pulse is dropped; IDLE accepts on the following cycle.
  assign accept  = (state == IDLE) && start_i && !done_o;
  assign cnt_inc = cnt + CNT_W'(1);
  assign busy_o  = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the operand buses to the shared arithmetic units.
  always_comb begin
    state_nxt = state;
    div_a_o   = 32'd0;
    div_b_o   = 32'd0;
    add_a_o   = 32'd0;
    add_b_o   = 32'd0;
    case (state)
      IDLE: if (accept) state_nxt = INIT;
      INIT: state_nxt = special_hit ? DONE : DIV;
      DIV: begin
        div_a_o   = a_reg;
        div_b_o   = x_reg;
        state_nxt = ADD;
      end
      ADD: begin
        add_a_o   = x_reg;
        add_b_o   = q_reg;
        state_nxt = (cnt_inc < ITERS_C) ? DIV : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iterate registers, counter and the result/done outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= 32'd0;
      x_reg  <= 32'd0;
      q_reg  <= 32'd0;
      cnt    <= '0;
      data_o <= 32'd0;
      done_o <= 1'b0;
    end else begin
      done_o <= (state == DONE);
      case (state)
        IDLE: if (accept) begin
          a_reg <= data_i;
          cnt   <= '0;
        end
        INIT: x_reg <= special_hit ? special_val : guess;
        DIV:  q_reg <= div_res_i;
        ADD: begin
          x_reg <= halve(add_res_i);
          cnt   <= cnt_inc;
        end
        DONE:    data_o <= x_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Self-checking bench for fp_sqrt_seq: ideal single-precision divider/adder
// models and a real-arithmetic Newton-Raphson reference.
`timescale 1ns/1ps
module tb_fp_sqrt_seq;

  localparam int ITERS = 4;
  localparam int LAT   = 2 + 2 * ITERS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;
  logic [31:0] div_a_o, div_b_o, div_res_i;
  logic [31:0] add_a_o, add_b_o, add_res_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fp_sqrt_seq #(.ITERS(ITERS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .data_i   (data_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .data_o   (data_o),
    .div_a_o  (div_a_o),
    .div_b_o  (div_b_o),
    .div_res_i(div_res_i),
    .add_a_o  (add_a_o),
    .add_b_o  (add_b_o),
    .add_res_i(add_res_i)
  );

  // Single float bits -> real (zero/subnormal treated as zero).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Real -> single float bits, round to nearest even.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [24:0] mr;
    logic        g, s;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'b0};
    e  = int'(d[62:52]) - 1023 + 127;
    g  = d[28];
    s  = |d[27:0];
    mr = {2'b01, d[51:29]} + 25'(g & (s | d[29]));
    if (mr[24]) begin
      mr = mr >> 1;
      e++;
    end
    if (e <= 0)   return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], e[7:0], mr[22:0]};
  endfunction

  // Ideal shared arithmetic units.
  assign div_res_i = (div_b_o[30:23] == 8'd0) ? 32'd0 : r2f(f2r(div_a_o) / f2r(div_b_o));
  assign add_res_i = r2f(f2r(add_a_o) + f2r(add_b_o));

  // Reference: power-of-two guess floor(e/2), then ITERS rounded Newton steps.
  function automatic logic [31:0] model_sqrt(input logic [31:0] a);
    int          e, h;
    real         g;
    logic [31:0] x, q, s;
`ifdef FP_SQRT_SPECIAL_EN
    if (a[30:23] == 8'd0)                           return 32'h0000_0000;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0)      return 32'h7FC0_0000;
    if (a[31])                                      return 32'h7FC0_0000;
    if (a[30:23] == 8'hFF)                          return 32'h7F80_0000;
`endif
    e = int'(a[30:23]) - 127;
    h = (e >= 0) ? e / 2 : -((1 - e) / 2);
    g = 1.0;
    if (h >= 0) repeat (h) g = g * 2.0;
    else        repeat (-h) g = g * 0.5;
    x = r2f(g);
    for (int i = 0; i < ITERS; i++) begin
      q = r2f(f2r(a) / f2r(x));
      s = r2f(f2r(x) + f2r(q));
      x = r2f(f2r(s) * 0.5);
    end
    return x;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one start pulse from IDLE; returns 1 ns after the accepting edge.
  task automatic issue(input logic [31:0] d);
    step();
    start_i = 1'b1;
    data_i  = d;
    step();
    start_i = 1'b0;
  endtask

  // Cycles counted from the current point until done_o, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!done_o && lat < 200);
    if (!done_o) check_eq("done_timeout", 32'(lat), 32'(LAT));
  endtask

  task automatic run_check(input string tag, input logic [31:0] d, input int exp_lat);
    int lat;
    issue(d);
    wait_done(lat);
    check_eq({tag, "_res"}, data_o, model_sqrt(d));
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int          lat, dones, diff;
    logic [31:0] res, d, d2;

    rst_n   = 1'b0;
    start_i = 1'b0;
    data_i  = 32'd0;
    repeat (3) step();
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_data", data_o, 32'd0);
    check_eq("rst_div_a", div_a_o, 32'd0);
    check_eq("rst_add_a", add_a_o, 32'd0);
    rst_n = 1'b1;

    // sqrt(4.0) with bus checks through INIT, DIV and ADD
    issue(32'h4080_0000);
    check_eq("init_busy", {31'd0, busy_o}, 32'd1);
    check_eq("init_div_a", div_a_o, 32'd0);
    check_eq("init_add_a", add_a_o, 32'd0);
    step();
    check_eq("div_a", div_a_o, 32'h4080_0000);
    check_eq("div_b", div_b_o, 32'h4000_0000);
    check_eq("div_add_a", add_a_o, 32'd0);
    step();
    check_eq("add_a", add_a_o, 32'h4000_0000);
    check_eq("add_b", add_b_o, 32'h4000_0000);
    check_eq("add_div_b", div_b_o, 32'd0);
    wait_done(lat);
    check_eq("sqrt4_res", data_o, 32'h4000_0000);
    check_eq("sqrt4_lat", 32'(lat + 2), 32'(LAT));
    step();
    check_eq("done_one_cycle", {31'd0, done_o}, 32'd0);

    run_check("sqrt16", 32'h4180_0000, LAT);
    check_eq("sqrt16_abs", data_o, 32'h4080_0000);

    run_check("sqrt2", 32'h4000_0000, LAT);
    diff = int'(data_o) - int'(32'h3FB5_04F3);
    check_eq("sqrt2_ulp", {31'd0, (diff <= 1 && diff >= -1)}, 32'd1);

    // starts while busy are ignored
    d  = 32'h4110_0000;
    d2 = 32'h4248_0000;
    issue(d);
    dones = 0;
    res   = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3 || c == 7) begin
        start_i = 1'b1;
        data_i  = d2;
      end
      step();
      start_i = 1'b0;
      if (done_o) begin
        dones++;
        res = data_o;
      end
    end
    check_eq("busy_start_dones", 32'(dones), 32'd1);
    check_eq("busy_start_res", res, model_sqrt(d));

    // start coinciding with done is ignored, accepted one cycle later
    d2 = 32'h4310_0000;
    issue(32'h4190_0000);
    wait_done(lat);
    start_i = 1'b1;
    data_i  = d2;
    step();
    check_eq("start_on_done_ignored", {31'd0, busy_o}, 32'd0);
    step();
    start_i = 1'b0;
    check_eq("start_after_done_busy", {31'd0, busy_o}, 32'd1);
    wait_done(lat);
    check_eq("start_after_done_res", data_o, model_sqrt(d2));
    check_eq("start_after_done_lat", 32'(lat), 32'(LAT));

    // reset in the middle of an operation
    issue(32'h4220_0000);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
    check_eq("abort_data", data_o, 32'd0);
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (done_o) dones++;
      step();
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);
    run_check("after_abort", 32'h4220_0000, LAT);

`ifdef FP_SQRT_SPECIAL_EN
    run_check("sp_neg", 32'hBF80_0000, 2);
    check_eq("sp_neg_abs", data_o, 32'h7FC0_0000);
    run_check("sp_zero", 32'h0000_0000, 2);
    check_eq("sp_zero_abs", data_o, 32'h0000_0000);
    run_check("sp_inf", 32'h7F80_0000, 2);
    run_check("sp_nan", 32'h7FC1_2345, 2);
`endif

    // randomized positive normal operands
    for (int i = 0; i < 24; i++) begin
      d = {1'b0, 8'($urandom_range(160, 96)), 23'($urandom)};
      run_check("rand", d, LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_seq.md
FP_SQRT_SEQ -- requirements
Module: fp_sqrt_seq

Interface
REQ-001 Parameter ITERS, default 4, is the number of Newton-Raphson iterations; legal range 1..15.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start_i  in  1  request to compute the square root of data_i; sampled only in IDLE.
REQ-005 data_i  in  32  IEEE-754 single operand; captured on the accepted start.
REQ-006 busy_o  out  1  high in every state except IDLE.
REQ-007 done_o  out  1  one-cycle pulse marking data_o as valid.
REQ-008 data_o  out  32  result; held until the next done_o.
REQ-009 div_a_o, div_b_o  out  32 each  operands to the shared external combinational FP divider (quotient = a/b).
REQ-010 div_res_i  in  32  divider result, valid in the same cycle.
REQ-011 add_a_o, add_b_o  out  32 each  operands to the shared external combinational FP adder.
REQ-012 add_res_i  in  32  adder sum, valid in the same cycle.

Function
REQ-013 The FSM SHALL have these states: IDLE, INIT, DIV, ADD, DONE.
REQ-014 IDLE -> INIT on start_i=1; data_i is registered as A, and the iteration counter is cleared.
REQ-015 INIT SHALL load guess X = {0, ((expA-127)>>>1)+127, 23'b0}, using an arithmetic shift on the signed unbiased exponent; next state is DIV.
REQ-016 DIV SHALL drive div_a_o=A and div_b_o=X, and latch Q=div_res_i; next state is ADD.
REQ-017 ADD SHALL drive add_a_o=X and add_b_o=Q, and form S=add_res_i.
REQ-018 In ADD, X SHALL be loaded with {S[31], S[30:23]-1, S[22:0]}, which halves S; if S[30:23]==0, X SHALL be loaded with 0.
REQ-019 ADD SHALL then increment the counter; next state is DIV if count<ITERS, otherwise DONE.
REQ-020 DONE SHALL load data_o=X and pulse done_o for exactly one cycle; next state is IDLE.
REQ-021 Latency from the accepting edge to done_o high SHALL be 2+2*ITERS cycles (10 for ITERS=4).
REQ-022 Outside DIV and ADD, the div_*_o and add_*_o outputs SHALL be driven to 0.
REQ-023 start_i asserted while busy_o=1 SHALL be ignored, with no queuing.
REQ-024 start_i asserted in the same cycle as the done_o pulse SHALL be ignored; a new start is accepted from IDLE on the following cycle.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear busy_o, done_o, data_o, A, X, Q and the counter.
REQ-026 Reset mid-operation SHALL abort the operation with no done_o pulse, and data_o SHALL read 0.

Configuration
REQ-027 Macro FP_SQRT_SPECIAL_EN SHALL control special-case handling in INIT.
- Defined: exp==0 -> result 0x00000000; negative with nonzero exp -> 0x7FC00000; +Inf -> 0x7F800000; NaN -> 0x7FC00000.
- Defined: every special case goes INIT -> DONE, so done_o is high 2 cycles after the accepting edge.
REQ-028 Without FP_SQRT_SPECIAL_EN, every operand SHALL take the full iteration path, and results for special operands are undefined.

Structure
REQ-029 Package fp_sqrt_pkg SHALL hold the state enum, BIAS=127, QNAN=0x7FC00000, PINF=0x7F800000, and the counter width (4 bits).
REQ-030 Sub-module fp_sqrt_guess SHALL be purely combinational: 32-bit operand in, initial guess X out (REQ-015).
REQ-031 The divider and adder SHALL stay outside this block, so they can be shared with other users.

Verification
The bench SHALL model the divider and adder with ideal IEEE single-precision arithmetic.
REQ-032 data_i=0x40800000 (4.0), ITERS=4 -> data_o=0x40000000, with done_o exactly 10 cycles after start.
REQ-033 data_i=0x41800000 (16.0) -> data_o=0x40800000; data_i=0x40000000 (2.0) -> data_o within 1 ulp of 0x3FB504F3.
REQ-034 With FP_SQRT_SPECIAL_EN defined:
- 0xBF800000 -> 0x7FC00000, with done_o 2 cycles after start.
- 0x00000000 -> 0x00000000, with done_o 2 cycles after start.
REQ-035 start_i pulsed at cycles 3 and 7 during a busy operation -> only one done_o, and the result matches the first operand.
REQ-036 rst_n=0 in cycle 5 of an operation -> no done_o, data_o=0, busy_o=0; the next start completes normally.
